// File: rtl/hazard_forward_pkg.sv
// Shared types for the hazard/forwarding unit: the in-flight slot record and
// the select-encoding helpers used by the top level and the priority matcher.
package hazard_forward_pkg;

  // Slots carry a fixed-width destination so the record can live here; the
  // top level zero-extends its ADDR_W-wide register numbers into this field.
  localparam int MAX_ADDR_W  = 16;
  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic                  valid;
    logic                  regwrite;
    logic [MAX_ADDR_W-1:0] dest;
    logic                  is_load;
  } slot_t;

  function automatic int sel_width(input int num_src);
    return (num_src < 1) ? 1 : $clog2(num_src + 1);
  endfunction

endpackage

// File: rtl/hfu_prio_match.sv
// Finds the youngest in-flight producer of one source operand and reports the
// operand-mux select it will need once the consumer has moved into EX.
module hfu_prio_match
  import hazard_forward_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int ADDR_W  = 5,
  parameter int SEL_W   = 2
) (
  input  slot_t [NUM_SRC:0]  i_slots,
  input  logic [ADDR_W-1:0]  i_op,
  input  logic               i_used,
  output logic               o_hit,
  output logic [SEL_W-1:0]   o_sel,
  output logic               o_is_load_hit
);

  logic [MAX_ADDR_W-1:0] w_op;
  logic [NUM_SRC:0]      w_match;

  assign w_op = MAX_ADDR_W'(i_op);

  always_comb begin
    for (int j = 0; j <= NUM_SRC; j++) begin
      w_match[j] = i_slots[j].valid & i_slots[j].regwrite &
                   (i_slots[j].dest != '0) & (i_slots[j].dest == w_op) & i_used;
    end
  end

  // Scan oldest to youngest so the youngest match is the last one written.
  // The oldest slot has already written the register file, so it still
  // claims priority over nothing younger but resolves to the register file.
  always_comb begin
    o_hit         = 1'b0;
    o_sel         = SEL_W'(FWD_REGFILE);
    o_is_load_hit = 1'b0;
    for (int j = NUM_SRC; j >= 0; j--) begin
      if (w_match[j]) begin
        o_hit         = 1'b1;
        o_sel         = (j == NUM_SRC) ? SEL_W'(FWD_REGFILE) : SEL_W'(j + 1);
        o_is_load_hit = i_slots[j].is_load;
      end
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// EX forwarding and load-use hazard unit: shadows in-flight destinations from
// EX onward and registers per-operand forwarding selects for the next EX op.
module hazard_forward_unit
  import hazard_forward_pkg::*;
#(
  parameter  int ADDR_W     = 5,
  parameter  int NUM_SRC    = 3,
  parameter  int LOAD_STAGE = 2,
  parameter  int CNT_W      = 16,
  localparam int SEL_W      = sel_width(NUM_SRC)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [ADDR_W-1:0] id_rs_i,
  input  logic [ADDR_W-1:0] id_rt_i,
  input  logic              id_uses_rs_i,
  input  logic              id_uses_rt_i,
  input  logic              id_regwrite_i,
  input  logic [ADDR_W-1:0] id_dest_i,
  input  logic              id_is_load_i,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic              stall_o,
  output logic [SEL_W-1:0]  fwd_a_o,
  output logic [SEL_W-1:0]  fwd_b_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [SEL_W-1:0] LOAD_SEL = SEL_W'(LOAD_STAGE);

  slot_t [NUM_SRC:0] r_slots;
  logic [SEL_W-1:0]  r_fwd_a;
  logic [SEL_W-1:0]  r_fwd_b;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_hit_a;
  logic              w_hit_b;
  logic [SEL_W-1:0]  w_sel_a;
  logic [SEL_W-1:0]  w_sel_b;
  logic              w_load_a;
  logic              w_load_b;
  logic [SEL_W-1:0]  w_fwd_a;
  logic [SEL_W-1:0]  w_fwd_b;
  logic              w_haz_a;
  logic              w_haz_b;
  logic              w_stall;
  logic              w_bubble;
  slot_t             w_id_slot;

  hfu_prio_match #(.NUM_SRC(NUM_SRC), .ADDR_W(ADDR_W), .SEL_W(SEL_W)) u_match_a (
    .i_slots       (r_slots),
    .i_op          (id_rs_i),
    .i_used        (id_uses_rs_i),
    .o_hit         (w_hit_a),
    .o_sel         (w_sel_a),
    .o_is_load_hit (w_load_a)
  );

  hfu_prio_match #(.NUM_SRC(NUM_SRC), .ADDR_W(ADDR_W), .SEL_W(SEL_W)) u_match_b (
    .i_slots       (r_slots),
    .i_op          (id_rt_i),
    .i_used        (id_uses_rt_i),
    .o_hit         (w_hit_b),
    .o_sel         (w_sel_b),
    .o_is_load_hit (w_load_b)
  );

  assign w_fwd_a = w_hit_a ? w_sel_a : SEL_W'(FWD_REGFILE);
  assign w_fwd_b = w_hit_b ? w_sel_b : SEL_W'(FWD_REGFILE);

  // A load hazard exists only when the youngest producer is a load whose data
  // cannot yet be forwarded from the source the consumer would select.
  assign w_haz_a  = w_load_a & (w_fwd_a != '0) & (w_fwd_a < LOAD_SEL);
  assign w_haz_b  = w_load_b & (w_fwd_b != '0) & (w_fwd_b < LOAD_SEL);
  assign w_stall  = id_valid_i & ~flush_i & (w_haz_a | w_haz_b);
  assign w_bubble = w_stall | flush_i | ~id_valid_i;

  always_comb begin
    w_id_slot          = '0;
    w_id_slot.valid    = 1'b1;
    w_id_slot.regwrite = id_regwrite_i;
    w_id_slot.dest     = MAX_ADDR_W'(id_dest_i);
    w_id_slot.is_load  = id_is_load_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_slots     <= '0;
      r_fwd_a     <= '0;
      r_fwd_b     <= '0;
      r_stall_cnt <= '0;
    end else if (!hold_i) begin
      for (int k = NUM_SRC; k >= 1; k--) begin
        r_slots[k] <= r_slots[k-1];
      end
      r_slots[0] <= w_bubble ? slot_t'('0) : w_id_slot;
      r_fwd_a    <= w_bubble ? SEL_W'(FWD_REGFILE) : w_fwd_a;
      r_fwd_b    <= w_bubble ? SEL_W'(FWD_REGFILE) : w_fwd_b;
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_o     = w_stall;
  assign fwd_a_o     = r_fwd_a;
  assign fwd_b_o     = r_fwd_b;
  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: expected selects are queued when an
// instruction is presented in ID and compared when it lands in EX.
module tb_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        rst, idValid, usesRs, usesRt, regWrite, isLoad, flush, hold;
  logic [4:0]  idRs, idRt, idDest;
  logic        stall, stall3;
  logic [1:0]  fwdA, fwdB, fwdA3, fwdB3;
  logic [15:0] stallCnt, stallCnt3;

  int nChecks = 0;
  int nFail   = 0;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic       p1v, p1rw, p1ld;
    logic [4:0] p1d;
    logic       p2v, p2rw, p2ld;
    logic [4:0] p2d;
    logic [4:0] crs, crt;
    logic       curs, curt;
    logic [1:0] expA, expB;
    int         expSt;
  } prio_case_t;

  always #5 clk = ~clk;

  hazard_forward_unit #(.ADDR_W(5), .NUM_SRC(3), .LOAD_STAGE(2), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(idValid), .id_rs_i(idRs), .id_rt_i(idRt),
    .id_uses_rs_i(usesRs), .id_uses_rt_i(usesRt), .id_regwrite_i(regWrite),
    .id_dest_i(idDest), .id_is_load_i(isLoad), .flush_i(flush), .hold_i(hold),
    .stall_o(stall), .fwd_a_o(fwdA), .fwd_b_o(fwdB), .stall_cnt_o(stallCnt)
  );

  hazard_forward_unit #(.ADDR_W(5), .NUM_SRC(3), .LOAD_STAGE(3), .CNT_W(16)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .id_valid_i(idValid), .id_rs_i(idRs), .id_rt_i(idRt),
    .id_uses_rs_i(usesRs), .id_uses_rt_i(usesRt), .id_regwrite_i(regWrite),
    .id_dest_i(idDest), .id_is_load_i(isLoad), .flush_i(flush), .hold_i(hold),
    .stall_o(stall3), .fwd_a_o(fwdA3), .fwd_b_o(fwdB3), .stall_cnt_o(stallCnt3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt, input logic rw,
                               input logic [4:0] dst, input logic ld);
    idValid = v; idRs = rs; idRt = rt; usesRs = urs; usesRt = urt;
    regWrite = rw; idDest = dst; isLoad = ld;
    #1;
  endtask

  task automatic applyNop();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic doReset();
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    applyNop();
    tick();
    rst = 1'b0;
  endtask

  task automatic pushExp(input logic [1:0] a, input logic [1:0] b);
    exp_t e;
    e.a = a; e.b = b;
    sbq.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1; hold = 1'b1; flush = 1'b0;
    applyStimulus(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1);
    tick();
    rst = 1'b0; hold = 1'b0;
    #1;
    nChecks++; if (fwdA !== 2'd0) begin nFail++; $display("[TB] FAIL reset_fwd_a got=%0d exp=0", fwdA); end
    nChecks++; if (fwdB !== 2'd0) begin nFail++; $display("[TB] FAIL reset_fwd_b got=%0d exp=0", fwdB); end
    nChecks++; if (stallCnt !== 16'd0) begin nFail++; $display("[TB] FAIL reset_cnt got=%0d exp=0", stallCnt); end
    nChecks++; if (stall !== 1'b0) begin nFail++; $display("[TB] FAIL reset_stall got=%0b exp=0", stall); end
    pushExp(2'd0, 2'd0);
    tick();
    e = sbq.pop_front();
    nChecks++; if (fwdA !== e.a || fwdB !== e.b) begin nFail++; $display("[TB] FAIL reset_first_issue got=%0d/%0d exp=%0d/%0d", fwdA, fwdB, e.a, e.b); end
  endtask

  task automatic test_alu_back_to_back();
    exp_t e;
    doReset();
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0);
    pushExp(2'd0, 2'd0);
    tick();
    e = sbq.pop_front();
    nChecks++; if (fwdA !== e.a || fwdB !== e.b) begin nFail++; $display("[TB] FAIL alu_producer got=%0d/%0d exp=%0d/%0d", fwdA, fwdB, e.a, e.b); end
    applyStimulus(1'b1, 5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0);
    nChecks++; if (stall !== 1'b0) begin nFail++; $display("[TB] FAIL alu_stall got=%0b exp=0", stall); end
    pushExp(2'd1, 2'd0);
    tick();
    e = sbq.pop_front();
    nChecks++; if (fwdA !== e.a || fwdB !== e.b) begin nFail++; $display("[TB] FAIL alu_consumer got=%0d/%0d exp=%0d/%0d", fwdA, fwdB, e.a, e.b); end
  endtask

  task automatic test_gap();
    exp_t e;
    logic [1:0] expB [3];
    expB[0] = 2'd2; expB[1] = 2'd3; expB[2] = 2'd0;
    for (int g = 1; g <= 3; g++) begin
      doReset();
      applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0);
      pushExp(2'd0, 2'd0);
      tick();
      e = sbq.pop_front();
      for (int n = 0; n < g; n++) begin
        applyNop();
        tick();
      end
      applyStimulus(1'b1, 5'd9, 5'd3, 1'b1, 1'b1, 1'b1, 5'd10, 1'b0);
      nChecks++; if (stall !== 1'b0) begin nFail++; $display("[TB] FAIL gap%0d_stall got=%0b exp=0", g, stall); end
      pushExp(2'd0, expB[g-1]);
      tick();
      e = sbq.pop_front();
      nChecks++; if (fwdA !== e.a || fwdB !== e.b) begin nFail++; $display("[TB] FAIL gap%0d_consumer got=%0d/%0d exp=%0d/%0d", g, fwdA, fwdB, e.a, e.b); end
    end
  endtask

  task automatic test_load_use();
    exp_t e;
    int stallCyc = 0, stallCyc3 = 0;
    bit done = 0, done3 = 0, iss, iss3;
    logic [1:0] got3 = 2'd0;
    doReset();
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1);
    tick();
    applyStimulus(1'b1, 5'd6, 5'd5, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0);
    pushExp(2'd0, 2'd2);
    for (int c = 0; c < 6; c++) begin
      iss  = !done && !stall;
      iss3 = !done3 && !stall3;
      if (!done && stall) stallCyc++;
      if (!done3 && stall3) stallCyc3++;
      tick();
      if (c == 0) begin
        nChecks++; if (fwdB !== 2'd0) begin nFail++; $display("[TB] FAIL loaduse_bubble got=%0d exp=0", fwdB); end
      end
      if (iss) begin
        done = 1;
        e = sbq.pop_front();
        nChecks++; if (fwdA !== e.a || fwdB !== e.b) begin nFail++; $display("[TB] FAIL loaduse_issue got=%0d/%0d exp=%0d/%0d", fwdA, fwdB, e.a, e.b); end
      end
      if (iss3) begin
        done3 = 1;
        got3 = fwdB3;
      end
    end
    nChecks++; if (!done) begin nFail++; $display("[TB] FAIL loaduse_timeout got=no_issue exp=issue"); void'(sbq.pop_front()); end
    nChecks++; if (stallCyc != 1) begin nFail++; $display("[TB] FAIL loaduse_stall_cycles got=%0d exp=1", stallCyc); end
    nChecks++; if (stallCnt !== 16'd1) begin nFail++; $display("[TB] FAIL loaduse_cnt got=%0d exp=1", stallCnt); end
    nChecks++; if (!done3) begin nFail++; $display("[TB] FAIL ls3_timeout got=no_issue exp=issue"); end
    nChecks++; if (stallCyc3 != 2) begin nFail++; $display("[TB] FAIL ls3_stall_cycles got=%0d exp=2", stallCyc3); end
    nChecks++; if (got3 !== 2'd3) begin nFail++; $display("[TB] FAIL ls3_fwd_b got=%0d exp=3", got3); end
    nChecks++; if (stallCnt3 !== 16'd2) begin nFail++; $display("[TB] FAIL ls3_cnt got=%0d exp=2", stallCnt3); end
  endtask

  task automatic test_priority();
    exp_t e;
    prio_case_t tbl [8];
    int nSt;
    tbl[0] = '{1, 1, 0, 4, 1, 1, 0, 4, 4, 9, 1, 1, 1, 0, 0};
    tbl[1] = '{1, 1, 0, 4, 1, 1, 0, 6, 4, 6, 1, 1, 2, 1, 0};
    tbl[2] = '{1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0};
    tbl[3] = '{1, 1, 0, 4, 1, 1, 0, 7, 4, 4, 0, 1, 0, 2, 0};
    tbl[4] = '{1, 0, 0, 4, 1, 1, 0, 7, 4, 7, 1, 1, 0, 1, 0};
    tbl[5] = '{0, 1, 0, 4, 1, 1, 0, 7, 4, 9, 1, 1, 0, 0, 0};
    tbl[6] = '{1, 1, 1, 4, 1, 1, 0, 4, 4, 9, 1, 1, 1, 0, 0};
    tbl[7] = '{1, 1, 0, 4, 1, 1, 1, 6, 4, 6, 1, 1, 3, 2, 1};
    for (int i = 0; i < 8; i++) begin
      doReset();
      applyStimulus(tbl[i].p1v, 5'd1, 5'd2, 1'b1, 1'b1, tbl[i].p1rw, tbl[i].p1d, tbl[i].p1ld);
      tick();
      applyStimulus(tbl[i].p2v, 5'd1, 5'd2, 1'b1, 1'b1, tbl[i].p2rw, tbl[i].p2d, tbl[i].p2ld);
      tick();
      applyStimulus(1'b1, tbl[i].crs, tbl[i].crt, tbl[i].curs, tbl[i].curt, 1'b1, 5'd10, 1'b0);
      pushExp(tbl[i].expA, tbl[i].expB);
      nSt = 0;
      while (stall === 1'b1 && nSt < 4) begin
        nSt++;
        tick();
      end
      nChecks++; if (nSt != tbl[i].expSt) begin nFail++; $display("[TB] FAIL prio%0d_stalls got=%0d exp=%0d", i, nSt, tbl[i].expSt); end
      tick();
      e = sbq.pop_front();
      nChecks++; if (fwdA !== e.a || fwdB !== e.b) begin nFail++; $display("[TB] FAIL prio%0d_sel got=%0d/%0d exp=%0d/%0d", i, fwdA, fwdB, e.a, e.b); end
    end
  endtask

  task automatic test_hold_flush();
    exp_t e;
    doReset();
    applyStimulus(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 5'd1, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1);
    pushExp(2'd1, 2'd0);
    tick();
    e = sbq.pop_front();
    nChecks++; if (fwdA !== e.a || fwdB !== e.b) begin nFail++; $display("[TB] FAIL hold_load_issue got=%0d/%0d exp=%0d/%0d", fwdA, fwdB, e.a, e.b); end
    applyStimulus(1'b1, 5'd6, 5'd5, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0);
    nChecks++; if (stall !== 1'b1) begin nFail++; $display("[TB] FAIL hold_pre_stall got=%0b exp=1", stall); end
    hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      nChecks++; if (stall !== 1'b1) begin nFail++; $display("[TB] FAIL hold%0d_stall got=%0b exp=1", c, stall); end
      nChecks++; if (fwdA !== 2'd1) begin nFail++; $display("[TB] FAIL hold%0d_fwd_a got=%0d exp=1", c, fwdA); end
      nChecks++; if (stallCnt !== 16'd0) begin nFail++; $display("[TB] FAIL hold%0d_cnt got=%0d exp=0", c, stallCnt); end
    end
    hold = 1'b0;
    tick();
    nChecks++; if (fwdA !== 2'd0 || fwdB !== 2'd0) begin nFail++; $display("[TB] FAIL hold_release_bubble got=%0d/%0d exp=0/0", fwdA, fwdB); end
    nChecks++; if (stallCnt !== 16'd1) begin nFail++; $display("[TB] FAIL hold_release_cnt got=%0d exp=1", stallCnt); end
    pushExp(2'd0, 2'd2);
    tick();
    e = sbq.pop_front();
    nChecks++; if (fwdA !== e.a || fwdB !== e.b) begin nFail++; $display("[TB] FAIL hold_consumer got=%0d/%0d exp=%0d/%0d", fwdA, fwdB, e.a, e.b); end

    doReset();
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1);
    tick();
    flush = 1'b1;
    applyStimulus(1'b1, 5'd6, 5'd5, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0);
    nChecks++; if (stall !== 1'b0) begin nFail++; $display("[TB] FAIL flush_stall got=%0b exp=0", stall); end
    tick();
    flush = 1'b0;
    nChecks++; if (fwdA !== 2'd0 || fwdB !== 2'd0) begin nFail++; $display("[TB] FAIL flush_fwd got=%0d/%0d exp=0/0", fwdA, fwdB); end
    nChecks++; if (stallCnt !== 16'd0) begin nFail++; $display("[TB] FAIL flush_cnt got=%0d exp=0", stallCnt); end
    applyStimulus(1'b1, 5'd8, 5'd5, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0);
    nChecks++; if (stall !== 1'b0) begin nFail++; $display("[TB] FAIL flush_next_stall got=%0b exp=0", stall); end
    pushExp(2'd0, 2'd2);
    tick();
    e = sbq.pop_front();
    nChecks++; if (fwdA !== e.a || fwdB !== e.b) begin nFail++; $display("[TB] FAIL flush_next_sel got=%0d/%0d exp=%0d/%0d", fwdA, fwdB, e.a, e.b); end
  endtask

  task automatic test_reset_mid_stall();
    exp_t e;
    bit found = 0;
    doReset();
    applyStimulus(1'b1, 5'd1, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1);
    for (int c = 0; c < 40 && !found; c++) begin
      if (stall === 1'b1 && stallCnt === 16'd7) found = 1;
      else tick();
    end
    nChecks++; if (!found) begin nFail++; $display("[TB] FAIL midstall_reach got=cnt%0d exp=cnt7_with_stall", stallCnt); end
    rst = 1'b1; hold = 1'b1;
    tick();
    rst = 1'b0; hold = 1'b0;
    #1;
    nChecks++; if (stall !== 1'b0) begin nFail++; $display("[TB] FAIL midstall_stall got=%0b exp=0", stall); end
    nChecks++; if (fwdA !== 2'd0 || fwdB !== 2'd0) begin nFail++; $display("[TB] FAIL midstall_fwd got=%0d/%0d exp=0/0", fwdA, fwdB); end
    nChecks++; if (stallCnt !== 16'd0) begin nFail++; $display("[TB] FAIL midstall_cnt got=%0d exp=0", stallCnt); end
    applyStimulus(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0);
    nChecks++; if (stall !== 1'b0) begin nFail++; $display("[TB] FAIL midstall_consumer_stall got=%0b exp=0", stall); end
    pushExp(2'd0, 2'd0);
    tick();
    e = sbq.pop_front();
    nChecks++; if (fwdA !== e.a || fwdB !== e.b) begin nFail++; $display("[TB] FAIL midstall_consumer_sel got=%0d/%0d exp=%0d/%0d", fwdA, fwdB, e.a, e.b); end
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    idValid = 1'b0; idRs = '0; idRt = '0; usesRs = 1'b0; usesRt = 1'b0;
    regWrite = 1'b0; idDest = '0; isLoad = 1'b0;
    test_reset();
    test_alu_back_to_back();
    test_gap();
    test_load_use();
    test_priority();
    test_hold_flush();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
